// File: rtl/mmio_log_responder.sv
// mmio_log_responder
//
// MMIO target sitting on the core-side request port. It decodes a 32-byte
// register window at BaseAddr. STOP writes raise a sticky stop flag and
// capture an exit code. LOG writes push byte-masked words into a small FIFO,
// and the FIFO is drained over a valid/ready stream. STATUS and WRCOUNT reads
// are answered with one cycle of registered latency.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset
//   req_i        request valid (single cycle, no backpressure)
//   we_i         1 = write, 0 = read
//   addr_i       byte address
//   wdata_i      write data
//   strb_i       byte strobes (used by writes only)
//   rdata_o      registered read data, loaded the cycle after a read
//   stop_o       sticky stop request
//   exit_code_o  exit code captured with the first stop
//   log_valid_o  FIFO head valid
//   log_data_o   FIFO head data
//   log_ready_i  consumer accepts the head
//   overflow_o   sticky flag: at least one log word was dropped
//
// Register map (offsets from BaseAddr, 8-byte aligned):
//   0x00 STOP (W)   0x08 LOG (W)   0x10 STATUS (R)   0x18 WRCOUNT (R)
module mmio_log_responder #(
  parameter int unsigned                MMIOAddrWidth = 31,
  parameter int unsigned                DataWidth     = 64,
  parameter logic [MMIOAddrWidth-1:0]   BaseAddr      = 31'h1000_0000,
  parameter int unsigned                FifoDepth     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [MMIOAddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]     wdata_i,
  input  logic [DataWidth/8-1:0]   strb_i,
  output logic [DataWidth-1:0]     rdata_o,
  output logic                     stop_o,
  output logic [30:0]              exit_code_o,
  output logic                     log_valid_o,
  output logic [DataWidth-1:0]     log_data_o,
  input  logic                     log_ready_i,
  output logic                     overflow_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxW      = $clog2(FifoDepth);
  localparam int unsigned PtrW      = IdxW + 1;

  localparam logic [1:0] RegStop    = 2'd0;
  localparam logic [1:0] RegLog     = 2'd1;
  localparam logic [1:0] RegStatus  = 2'd2;
  localparam logic [1:0] RegWrcount = 2'd3;

  localparam logic [DataWidth-1:0] MissData = 64'hDEAD_BEEF_DEAD_BEEF;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [MMIOAddrWidth-1:0] off;
  logic                     hit;
  logic [1:0]               reg_sel;

  // The lower-bound compare is needed because the subtraction wraps for
  // addresses below BaseAddr, which would otherwise alias into the window.
  assign off     = addr_i - BaseAddr;
  assign hit     = (addr_i >= BaseAddr) &&
                   (off < MMIOAddrWidth'(32)) &&
                   (addr_i[2:0] == 3'b000);
  assign reg_sel = off[4:3];

  logic wr_req;
  logic rd_req;
  logic stop_wr;
  logic log_wr;

  assign wr_req  = req_i & we_i;
  assign rd_req  = req_i & ~we_i;
  assign stop_wr = wr_req & hit & (reg_sel == RegStop) & strb_i[0] & wdata_i[0];
  assign log_wr  = wr_req & hit & (reg_sel == RegLog);

  // ---------------------------------------------------------------------
  // Log FIFO
  // ---------------------------------------------------------------------
  logic [PtrW-1:0]      wptr;
  logic [PtrW-1:0]      rptr;
  logic [PtrW-1:0]      level;
  logic [8:0]           level_ext;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 push_drop;
  logic [DataWidth-1:0] push_data;
  logic [DataWidth-1:0] mem [FifoDepth];

  // The extra pointer bit separates full from empty, so the difference of
  // the pointers is the occupancy directly.
  assign level     = wptr - rptr;
  assign level_ext = 9'(level);
  assign full      = (level == PtrW'(FifoDepth));
  assign pop       = log_valid_o & log_ready_i;

  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push      = log_wr & (~full | pop);
  assign push_drop = log_wr & full & ~pop;

  // Byte lanes without a strobe are stored as zero.
  always_comb begin
    push_data = '0;
    for (int b = 0; b < StrbWidth; b++) begin
      if (strb_i[b]) begin
        push_data[b*8 +: 8] = wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PtrW'(1);
      end
      if (pop) begin
        rptr <= rptr + PtrW'(1);
      end
    end
  end

  // Storage is not reset; the pointers decide what is visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr[IdxW-1:0]] <= push_data;
    end
  end

  // Data is gated by valid so stale storage never shows on the stream,
  // in particular right after reset.
  assign log_valid_o = (level != '0);
  assign log_data_o  = log_valid_o ? mem[rptr[IdxW-1:0]] : '0;

  // ---------------------------------------------------------------------
  // Stop / exit code, overflow, counters
  // ---------------------------------------------------------------------
  logic [31:0] drop_cnt;
  logic [31:0] wrcount;

  // The first accepted stop wins; later stops cannot change the exit code.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stop_o      <= 1'b0;
      exit_code_o <= '0;
    end else if (stop_wr && !stop_o) begin
      stop_o      <= 1'b1;
      exit_code_o <= wdata_i[31:1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      drop_cnt   <= '0;
    end else if (push_drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt != 32'hFFFF_FFFF) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end

  // Counts every write cycle, including misses; wraps naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrcount <= '0;
    end else if (wr_req) begin
      wrcount <= wrcount + 32'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [DataWidth-1:0] rd_value;

  // Values are taken from current registers, i.e. before any update that
  // happens in the same cycle as the read.
  always_comb begin
    rd_value = MissData;
    if (hit) begin
      case (reg_sel)
        RegStatus:  rd_value = {drop_cnt, 8'h00, level_ext[7:0], 14'h0000,
                                overflow_o, stop_o};
        RegWrcount: rd_value = {32'h0000_0000, wrcount};
        default:    rd_value = MissData;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (rd_req) begin
      rdata_o <= rd_value;
    end
  end

endmodule

// File: tb/tb_mmio_log_responder.sv
// Testbench for mmio_log_responder.
// Directed steps in one initial block; a reference model predicts log words
// (queued on push, compared when the consumer takes them) and read data
// (queued on the read request, compared one cycle later).
module tb_mmio_log_responder;

  localparam logic [30:0] BASE = 31'h1000_0000;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam int          DEPTH = 8;

  logic        clk_i;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [30:0] addr_i;
  logic [63:0] wdata_i;
  logic [7:0]  strb_i;
  logic [63:0] rdata_o;
  logic        stop_o;
  logic [30:0] exit_code_o;
  logic        log_valid_o;
  logic [63:0] log_data_o;
  logic        log_ready_i;
  logic        overflow_o;

  mmio_log_responder #(
    .MMIOAddrWidth(31),
    .DataWidth(64),
    .BaseAddr(BASE),
    .FifoDepth(DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .we_i(we_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .strb_i(strb_i),
    .rdata_o(rdata_o),
    .stop_o(stop_o),
    .exit_code_o(exit_code_o),
    .log_valid_o(log_valid_o),
    .log_data_o(log_data_o),
    .log_ready_i(log_ready_i),
    .overflow_o(overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] log_q [$];
  logic [63:0] rd_q  [$];
  int          exp_level;
  logic [31:0] exp_drop;
  logic        exp_overflow;
  logic        exp_stop;
  logic [30:0] exp_exit;
  logic [31:0] exp_wrcount;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    log_q.delete();
    rd_q.delete();
    exp_level    = 0;
    exp_drop     = '0;
    exp_overflow = 1'b0;
    exp_stop     = 1'b0;
    exp_exit     = '0;
    exp_wrcount  = '0;
  endtask

  function automatic logic [63:0] maskData(input logic [63:0] d, input logic [7:0] s);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] modelStatus();
    logic [7:0] lv;
    lv = 8'(exp_level);
    return {exp_drop, 8'h00, lv, 14'h0000, exp_overflow, exp_stop};
  endfunction

  // Drives one bus cycle (called just after a rising edge), predicts the
  // outcome, and checks the registered results after the following edge.
  task automatic applyStimulus(input logic req, input logic we, input logic [30:0] addr,
                               input logic [63:0] wdata, input logic [7:0] strb,
                               input logic ready);
    logic        popping;
    logic        hit;
    logic [30:0] off;
    logic [1:0]  sel;
    logic [63:0] exp_word;
    req_i = req; we_i = we; addr_i = addr; wdata_i = wdata; strb_i = strb;
    log_ready_i = ready;
    #1;
    checkOutput("log_valid", {63'h0, log_valid_o}, {63'h0, exp_level != 0});
    popping = ready && (exp_level != 0);
    if (popping) begin
      if (log_q.size() == 0) begin
        checkOutput("log_q_underflow", 64'd0, 64'd1);
      end else begin
        exp_word = log_q.pop_front();
        checkOutput("log_data", log_data_o, exp_word);
      end
    end
    off = addr - BASE;
    hit = (addr >= BASE) && (off < 31'd32) && (addr[2:0] == 3'b000);
    sel = off[4:3];
    if (req && !we) begin
      if (hit && sel == 2'd2)      rd_q.push_back(modelStatus());
      else if (hit && sel == 2'd3) rd_q.push_back({32'h0, exp_wrcount});
      else                         rd_q.push_back(DEAD);
    end
    if (req && we) begin
      exp_wrcount = exp_wrcount + 32'd1;
      if (hit && sel == 2'd0 && strb[0] && wdata[0] && !exp_stop) begin
        exp_stop = 1'b1;
        exp_exit = wdata[31:1];
      end
      if (hit && sel == 2'd1) begin
        if (exp_level < DEPTH || popping) begin
          log_q.push_back(maskData(wdata, strb));
          exp_level++;
        end else begin
          exp_overflow = 1'b1;
          if (exp_drop != 32'hFFFF_FFFF) exp_drop = exp_drop + 32'd1;
        end
      end
    end
    if (popping) exp_level--;
    @(posedge clk_i);
    #1;
    req_i = 1'b0; we_i = 1'b0;
    if (req && !we) checkOutput("rdata", rdata_o, rd_q.pop_front());
    checkOutput("stop", {63'h0, stop_o}, {63'h0, exp_stop});
    checkOutput("exit_code", {33'h0, exit_code_o}, {33'h0, exp_exit});
    checkOutput("overflow", {63'h0, overflow_o}, {63'h0, exp_overflow});
  endtask

  task automatic wr(input logic [30:0] a, input logic [63:0] d, input logic [7:0] s, input logic rdy);
    applyStimulus(1'b1, 1'b1, a, d, s, rdy);
  endtask

  task automatic rd(input logic [30:0] a);
    applyStimulus(1'b1, 1'b0, a, 64'h0, 8'h00, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 1'b0, 31'h0, 64'h0, 8'h00, rdy);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rdata"}, rdata_o, 64'h0);
    checkOutput({tag, "_stop"}, {63'h0, stop_o}, 64'h0);
    checkOutput({tag, "_exit"}, {33'h0, exit_code_o}, 64'h0);
    checkOutput({tag, "_valid"}, {63'h0, log_valid_o}, 64'h0);
    checkOutput({tag, "_data"}, log_data_o, 64'h0);
    checkOutput({tag, "_overflow"}, {63'h0, overflow_o}, 64'h0);
  endtask

  task automatic syncReset();
    rst_i = 1'b1;
    #3;
    checkAllZero("reset");
    modelReset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    strb_i = '0; log_ready_i = 1'b0;
    modelReset();
    @(posedge clk_i);
    #1;
    syncReset();

    // 1: single full-strobe log word, visible from the next cycle
    $display("[TB] step 1: log word and status level");
    wr(BASE + 31'h08, 64'h1122_3344_5566_7788, 8'hFF, 1'b0);
    checkOutput("t1_head", log_data_o, 64'h1122_3344_5566_7788);
    rd(BASE + 31'h10);
    checkOutput("t1_status", rdata_o, 64'h0000_0000_0001_0000);

    // 2: partial strobes zero the unselected lanes
    $display("[TB] step 2: byte masking and drain");
    wr(BASE + 31'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0);
    idle(1'b1);
    checkOutput("t2_head", log_data_o, 64'h0000_0000_FFFF_FFFF);
    idle(1'b1);
    checkOutput("t2_empty", {63'h0, log_valid_o}, 64'h0);

    // 3: overflow, then a push accepted into a full FIFO alongside a pop
    $display("[TB] step 3: overflow");
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr(BASE + 31'h08, 64'h100 + 64'(i), 8'hFF, 1'b0);
    end
    rd(BASE + 31'h10);
    checkOutput("t3_status", rdata_o, 64'h0000_0002_0008_0002);
    wr(BASE + 31'h08, 64'hCAFE_0000_0000_0001, 8'hFF, 1'b1);
    rd(BASE + 31'h10);
    checkOutput("t3_status_after", rdata_o, 64'h0000_0002_0008_0002);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);
    checkOutput("t3_drained", {63'h0, log_valid_o}, 64'h0);

    // 4: first stop wins
    $display("[TB] step 4: stop and exit code");
    wr(BASE, 64'h0000_0000_0000_002B, 8'h01, 1'b0);
    checkOutput("t4_exit", {33'h0, exit_code_o}, 64'h15);
    wr(BASE, 64'h0000_0000_0000_0003, 8'h01, 1'b0);
    checkOutput("t4_exit_kept", {33'h0, exit_code_o}, 64'h15);

    // 5: read misses and write counting of unmapped writes
    $display("[TB] step 5: misses and write count");
    syncReset();
    rd(BASE + 31'h04);
    rd(BASE + 31'h40);
    checkOutput("t5_miss", rdata_o, DEAD);
    rd(BASE);
    wr(BASE + 31'h20, 64'h1, 8'hFF, 1'b0);
    wr(BASE - 31'h08, 64'h1, 8'hFF, 1'b0);
    wr(BASE + 31'h09, 64'h1, 8'hFF, 1'b0);
    rd(BASE + 31'h18);
    checkOutput("t5_wrcount", rdata_o, 64'd3);

    // 6: asynchronous reset in the middle of a cycle drops the FIFO
    $display("[TB] step 6: async reset mid-operation");
    for (int i = 0; i < 4; i++) wr(BASE + 31'h08, 64'h5000 + 64'(i), 8'hFF, 1'b0);
    wr(BASE, 64'h3, 8'h01, 1'b0);
    rd(BASE + 31'h10);
    #3;
    rst_i = 1'b1;
    #1;
    checkAllZero("t6_async");
    modelReset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    wr(BASE + 31'h08, 64'hA5, 8'hFF, 1'b0);
    checkOutput("t6_head", log_data_o, 64'hA5);
    idle(1'b1);
    checkOutput("t6_empty", {63'h0, log_valid_o}, 64'h0);
    checkOutput("t6_queue_empty", 64'(log_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
